// File: rtl/face_instr_issuer.sv
// Frodo host instruction issuer: queues 27-bit payloads, wraps them with OPCODE, issues one word at a time.
// Latency: push into an empty FIFO with the FSM idle reaches instr_valid two cycles later; one idle bubble follows each handshake.
// Backpressure: host_ready drops when the FIFO is full or flushing, and a LAUNCH holds issue until eng_done or the watchdog expires.
module face_instr_issuer #(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [4:0]  OPCODE         = 5'b10101,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              host_valid,
    input  logic [26:0]                       host_payload,
    output logic                              host_ready,
    input  logic                              flush,
    output logic [31:0]                       instr,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    input  logic                              eng_done,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                       done_count,
    output logic                              err,
    input  logic                              err_clr
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int WW = $clog2(TIMEOUT_CYCLES+1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t          state_q, state_d;
    logic [26:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [15:0]     done_q, done_d;
    logic            err_q, err_d;
    logic            full, push, pop;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign host_ready = !full && !flush && !rst;
    assign push       = host_valid && host_ready;
    // flush outranks the pop so nothing escapes a FIFO being cleared
    assign pop        = (state_q == IDLE) && (count_q != '0) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= host_payload;
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        wdog_d        = wdog_q;
        done_d        = done_q;
        err_d         = err_clr ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    instr_d       = {OPCODE, mem_q[rd_ptr_q]};
                    instr_valid_d = 1'b1;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (instr_q[23:22] == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_DONE;
                        wdog_d  = '0;
                    end
                end
            end
            WAIT_DONE: begin
                // completion beats a watchdog expiring in the same cycle
                if (eng_done) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end else if (wdog_q == WW'(TIMEOUT_CYCLES-1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d  = wdog_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            wdog_q        <= '0;
            done_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            wdog_q        <= wdog_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign fifo_count  = count_q;
    assign done_count  = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_face_instr_issuer.sv
// Bench for face_instr_issuer: directed scenarios plus random traffic, all compared every cycle to a queue-based model.
module tb_face_instr_issuer;
    localparam int D = 8;
    localparam int T = 4096;
    localparam logic [4:0] OP = 5'b10101;

    logic        clk, rst, host_valid, host_ready, flush, instr_valid, instr_ready;
    logic        eng_done, busy, err, err_clr;
    logic [26:0] host_payload;
    logic [31:0] instr;
    logic [3:0]  fifo_count;
    logic [15:0] done_count;

    face_instr_issuer #(.FIFO_DEPTH(D), .OPCODE(OP), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .host_valid(host_valid), .host_payload(host_payload),
        .host_ready(host_ready), .flush(flush), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .eng_done(eng_done), .busy(busy), .fifo_count(fifo_count),
        .done_count(done_count), .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !instr_valid; i++) tick();
        check("wait_valid", instr_valid, 1'b1);
    endtask

    // Reference model: a payload queue plus "what is the engine port doing" bookkeeping.
    logic [26:0] mq[$];
    int          m_phase = 0;   // 0 nothing outstanding, 1 word offered, 2 launch in flight
    logic [31:0] m_instr = '0;
    bit          m_vld = 0;
    int          m_wait = 0;
    int          m_done = 0;
    bit          m_err = 0;
    bit          fl, pu, po, to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_phase = 0; m_instr = '0; m_vld = 0; m_wait = 0; m_done = 0; m_err = 0;
        end else begin
            fl = flush;
            pu = host_valid && !fl && (mq.size() < D);
            po = (m_phase == 0) && (mq.size() > 0) && !fl;
            to = 0;
            case (m_phase)
                0: if (po) begin m_instr = {OP, mq[0]}; m_vld = 1; m_phase = 1; end
                1: if (instr_ready) begin
                       m_vld = 0;
                       m_phase = (m_instr[23:22] == 2'd0) ? 0 : 2;
                       m_wait = 0;
                   end
                default: begin
                    if (eng_done) begin m_done = (m_done + 1) % 65536; m_phase = 0; end
                    else if (m_wait == T - 1) begin to = 1; m_phase = 0; end
                    else m_wait++;
                end
            endcase
            if (to) m_err = 1;
            else if (err_clr) m_err = 0;
            if (fl) mq.delete();
            else begin
                if (po) void'(mq.pop_front());
                if (pu) mq.push_back(host_payload);
            end
        end
    end

    always @(negedge clk) begin
        check("host_ready", host_ready, !rst && !flush && (mq.size() < D));
        check("instr", instr, m_instr);
        check("instr_valid", instr_valid, m_vld);
        check("busy", busy, (m_phase != 0) || (mq.size() != 0));
        check("fifo_count", fifo_count, mq.size());
        check("done_count", done_count, m_done);
        check("err", err, m_err);
    end

    logic [26:0] p;
    int          n, k;

    initial begin
        rst = 1; host_valid = 0; host_payload = '0; flush = 0;
        instr_ready = 0; eng_done = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_host_ready", host_ready, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_fifo_count", fifo_count, 4'd0);
        check("rst_busy", busy, 1'b0);
        rst = 0;
        tick();

        // single SET: two-cycle latency and exact word
        host_valid = 1; host_payload = {3'd2, 2'd0, 1'b1, 21'h00040};
        tick();
        host_valid = 0;
        check("lat_n1", instr_valid, 1'b0);
        tick();
        check("lat_n2", instr_valid, 1'b1);
        check("set_word", instr, 32'hAA200040);
        instr_ready = 1; tick(); instr_ready = 0;
        check("set_hs_clears", instr_valid, 1'b0);
        tick();
        check("set_no_count", done_count, 16'd0);

        // LAUNCH then SET: second word two cycles after eng_done
        host_valid = 1; host_payload = {3'd1, 2'd1, 1'b0, 21'h1};
        tick();
        host_payload = {3'd7, 2'd0, 1'b1, 21'h1ABCDE};
        tick();
        host_valid = 0;
        wait_valid();
        check("launch_word", instr, 32'hA9400001);
        instr_ready = 1; tick(); instr_ready = 0;
        repeat (9) tick();
        check("held_in_wait", instr_valid, 1'b0);
        eng_done = 1; tick(); eng_done = 0;
        check("done_m1", instr_valid, 1'b0);
        tick();
        check("done_m2", instr_valid, 1'b1);
        check("second_word", instr, 32'hAF3ABCDE);
        check("done_one", done_count, 16'd1);
        instr_ready = 1; tick(); instr_ready = 0;
        tick();

        // fill with the engine stalled, then drain in order
        for (int i = 0; i < 10; i++) begin
            host_valid = 1; host_payload = {3'(i), 2'd0, 1'b0, 21'(i * 3 + 5)};
            tick();
        end
        host_valid = 0;
        check("full_count", fifo_count, 4'd8);
        check("full_ready", host_ready, 1'b0);
        instr_ready = 1;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (instr_valid) begin
                check("drain_order", instr, {OP, 3'(k), 2'd0, 1'b0, 21'(k * 3 + 5)});
                k++;
            end
            tick();
        end
        check("drain_total", k, 9);
        instr_ready = 0;

        // watchdog expiry
        host_valid = 1; host_payload = {3'd4, 2'd2, 1'b1, 21'h12345};
        tick(); host_valid = 0;
        wait_valid();
        instr_ready = 1; tick(); instr_ready = 0;
        n = 0;
        while (!err && n < T + 20) begin tick(); n++; end
        check("timeout_cycles", n, T);
        check("timeout_idle", busy, 1'b0);
        err_clr = 1; tick(); err_clr = 0;
        check("err_cleared", err, 1'b0);
        eng_done = 1; tick(); eng_done = 0; tick();
        check("stray_done", done_count, 16'd1);

        // flush with pending launch
        host_valid = 1; host_payload = {3'd3, 2'd3, 1'b0, 21'h777};
        tick(); host_valid = 0;
        wait_valid();
        instr_ready = 1; tick(); instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1; host_payload = {3'd0, 2'd0, 1'b0, 21'(i)};
            tick();
        end
        check("pre_flush_count", fifo_count, 4'd3);
        flush = 1; host_valid = 1; host_payload = 27'h5555;
        #1;
        check("flush_ready", host_ready, 1'b0);
        tick();
        flush = 0; host_valid = 0;
        check("flush_count", fifo_count, 4'd0);
        eng_done = 1; tick(); eng_done = 0;
        check("flush_done", done_count, 16'd2);
        tick();
        check("flush_no_issue", instr_valid, 1'b0);

        // async reset during ISSUE
        host_valid = 1; host_payload = {3'd5, 2'd1, 1'b1, 21'hABC};
        tick(); host_valid = 0;
        wait_valid();
        #2; rst = 1; #1;
        check("arst_valid", instr_valid, 1'b0);
        check("arst_instr", instr, 32'h0);
        check("arst_ready", host_ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done_count, 16'd0);
        @(posedge clk); #1; rst = 0;
        tick();
        eng_done = 1; tick(); eng_done = 0; tick();
        check("late_done", done_count, 16'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            host_valid   = 1'($urandom_range(0, 1));
            host_payload = 27'($urandom);
            instr_ready  = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 49) == 0);
            eng_done     = ($urandom_range(0, 7) == 0);
            err_clr      = ($urandom_range(0, 31) == 0);
            tick();
        end
        host_valid = 0; flush = 0; eng_done = 0; err_clr = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
